// File: rtl/clock_reset_sequencer.sv
// Clock/reset sequencer for the PLL and clock-buffer subsystem.
// Holds the shared PLL in reset, waits for every PLL to lock and stay locked,
// then releases the domain resets one at a time. A lost lock or a lock timeout
// retries the sequence. After MAX_RETRIES consecutive failures it halts until
// software requests a restart.
// Ports:
//   clk_600m            sequencer clock
//   rst_n               asynchronous active-low reset
//   pll_locked_async_i  raw PLL lock flags (asynchronous)
//   sw_restart_i        single-cycle restart request
//   pll_areset_o        PLL reset, active high
//   domain_rst_n_o      per-domain resets, active low (index 0 released first)
//   all_ready_o         high only in RUN
//   fault_halt_o        high only in HALT
//   seq_state_o         current state encoding
//   retry_count_o       consecutive failed attempts
//   lock_loss_count_o   lock losses seen in RUN, saturating
module clock_reset_sequencer #(
   parameter int unsigned NUM_PLL        = 4,
   parameter int unsigned NUM_DOM        = 4,
   parameter int unsigned ARESET_CYCLES  = 64,
   parameter int unsigned LOCK_TIMEOUT   = 65535,
   parameter int unsigned SETTLE_CYCLES  = 1024,
   parameter int unsigned STAGGER_CYCLES = 32,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic               clk_600m,
   input  logic               rst_n,
   input  logic [NUM_PLL-1:0] pll_locked_async_i,
   input  logic               sw_restart_i,
   output logic               pll_areset_o,
   output logic [NUM_DOM-1:0] domain_rst_n_o,
   output logic               all_ready_o,
   output logic               fault_halt_o,
   output logic [2:0]         seq_state_o,
   output logic [3:0]         retry_count_o,
   output logic [7:0]         lock_loss_count_o
);

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned ST_W    = 3;
   localparam int unsigned RETRY_W = 4;
   localparam int unsigned LOSS_W  = 8;

   typedef enum logic [ST_W-1:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      SETTLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5,
      HALT      = 3'd6
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic [LOSS_W-1:0]    loss_q, loss_d;
   logic [NUM_PLL-1:0]   sync1_q, sync2_q;
   logic                 pll_areset_q, pll_areset_d;
   logic [NUM_DOM-1:0]   dom_q, dom_d;
   logic                 all_ready_q, all_ready_d;
   logic                 fault_halt_q, fault_halt_d;
   logic [ST_W-1:0]      seq_state_q, seq_state_d;

   logic                 locked_all;
   logic                 stagger_done;
   logic [NUM_DOM-1:0]   dom_thermo_next;

   assign locked_all      = &sync2_q;
   assign stagger_done    = (cnt_q == CNT_W'(STAGGER_CYCLES - 1));
   // Thermometer step: shifts in one more released domain from index 0 upward.
   assign dom_thermo_next = (dom_q << 1) | NUM_DOM'(1);

   // State, counters, lock synchronizer and registered outputs.
   always_ff @(posedge clk_600m or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= PLL_RST;
         cnt_q        <= '0;
         retry_q      <= '0;
         loss_q       <= '0;
         sync1_q      <= '0;
         sync2_q      <= '0;
         pll_areset_q <= 1'b1;
         dom_q        <= '0;
         all_ready_q  <= 1'b0;
         fault_halt_q <= 1'b0;
         seq_state_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         loss_q       <= loss_d;
         sync1_q      <= pll_locked_async_i;
         sync2_q      <= sync1_q;
         pll_areset_q <= pll_areset_d;
         dom_q        <= dom_d;
         all_ready_q  <= all_ready_d;
         fault_halt_q <= fault_halt_d;
         seq_state_q  <= seq_state_d;
      end
   end

   // Next-state and counter logic; sw_restart overrides everything.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      retry_d = retry_q;
      loss_d  = loss_q;
      case (state_q)
         PLL_RST: begin
            if (cnt_q == CNT_W'(ARESET_CYCLES - 1)) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         WAIT_LOCK: begin
            if (locked_all) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               state_d = FAULT;
               cnt_d   = '0;
               retry_d = retry_q + RETRY_W'(1);
            end
         end
         SETTLE: begin
            if (!locked_all) begin
               // A glitch during settle just restarts the lock wait.
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               cnt_d = '0;
               if (NUM_DOM == 1) begin
                  state_d = RUN;
                  retry_d = '0;
               end else begin
                  state_d = RELEASE;
               end
            end
         end
         RELEASE: begin
            if (!locked_all) begin
               state_d = FAULT;
               cnt_d   = '0;
               retry_d = retry_q + RETRY_W'(1);
            end else if (stagger_done) begin
               cnt_d = '0;
               if (&dom_thermo_next) begin
                  state_d = RUN;
                  retry_d = '0;
               end
            end
         end
         RUN: begin
            cnt_d = '0;
            if (!locked_all) begin
               state_d = FAULT;
               retry_d = retry_q + RETRY_W'(1);
               if (loss_q != '1) loss_d = loss_q + LOSS_W'(1);
            end
         end
         FAULT: begin
            cnt_d   = '0;
            state_d = (retry_q == RETRY_W'(MAX_RETRIES)) ? HALT : PLL_RST;
         end
         HALT: begin
            cnt_d = '0;
         end
         default: begin
            state_d = PLL_RST;
            cnt_d   = '0;
         end
      endcase
      if (sw_restart_i) begin
         state_d = PLL_RST;
         cnt_d   = '0;
         retry_d = '0;
         loss_d  = loss_q;
      end
   end

   // Output values for the edge that moves into state_d.
   always_comb begin
      pll_areset_d = (state_d == PLL_RST) || (state_d == FAULT) || (state_d == HALT);
      all_ready_d  = (state_d == RUN);
      fault_halt_d = (state_d == HALT);
      seq_state_d  = ST_W'(state_d);
      dom_d        = dom_q;
      if (!((state_d == RELEASE) || (state_d == RUN))) begin
         dom_d = '0;
      end else if (state_q == SETTLE) begin
         dom_d = NUM_DOM'(1);
      end else if ((state_q == RELEASE) && stagger_done) begin
         dom_d = dom_thermo_next;
      end
   end

   assign pll_areset_o      = pll_areset_q;
   assign domain_rst_n_o    = dom_q;
   assign all_ready_o       = all_ready_q;
   assign fault_halt_o      = fault_halt_q;
   assign seq_state_o       = seq_state_q;
   assign retry_count_o     = retry_q;
   assign lock_loss_count_o = loss_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed bench for clock_reset_sequencer using the reduced timing set
// (ARESET 8, timeout 100, settle 16, stagger 4, 3 retries).
module tb_clock_reset_sequencer;

   logic       clk_600m;
   logic       rst_n;
   logic [3:0] pll_locked_async_i;
   logic       sw_restart_i;
   logic       pll_areset_o;
   logic [3:0] domain_rst_n_o;
   logic       all_ready_o;
   logic       fault_halt_o;
   logic [2:0] seq_state_o;
   logic [3:0] retry_count_o;
   logic [7:0] lock_loss_count_o;

   int n_cmp = 0;
   int n_err = 0;

   clock_reset_sequencer #(
      .NUM_PLL(4), .NUM_DOM(4), .ARESET_CYCLES(8), .LOCK_TIMEOUT(100),
      .SETTLE_CYCLES(16), .STAGGER_CYCLES(4), .MAX_RETRIES(3)
   ) dut (
      .clk_600m          (clk_600m),
      .rst_n             (rst_n),
      .pll_locked_async_i(pll_locked_async_i),
      .sw_restart_i      (sw_restart_i),
      .pll_areset_o      (pll_areset_o),
      .domain_rst_n_o    (domain_rst_n_o),
      .all_ready_o       (all_ready_o),
      .fault_halt_o      (fault_halt_o),
      .seq_state_o       (seq_state_o),
      .retry_count_o     (retry_count_o),
      .lock_loss_count_o (lock_loss_count_o)
   );

   initial clk_600m = 1'b0;
   always #5 clk_600m = ~clk_600m;

   // Advance n rising edges, then settle 1 time unit past the last edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk_600m);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pll_locked_async_i = 4'h0;
      sw_restart_i = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (seq_state_o !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", seq_state_o); end
      n_cmp++; if (pll_areset_o !== 1'b1) begin n_err++; $display("FAIL reset_areset: got %b want 1", pll_areset_o); end
      n_cmp++; if (domain_rst_n_o !== 4'h0) begin n_err++; $display("FAIL reset_dom: got %b want 0000", domain_rst_n_o); end
      n_cmp++; if ({all_ready_o, fault_halt_o} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {all_ready_o, fault_halt_o}); end
      n_cmp++; if ({retry_count_o, lock_loss_count_o} !== 12'h000) begin n_err++; $display("FAIL reset_counts: got %h want 000", {retry_count_o, lock_loss_count_o}); end
   endtask

   task automatic test_bringup();
      do_reset();
      step(7);
      n_cmp++; if ({seq_state_o, pll_areset_o} !== {3'd0, 1'b1}) begin n_err++; $display("FAIL areset_hold: state=%0d areset=%b want 0/1", seq_state_o, pll_areset_o); end
      step(1);
      n_cmp++; if ({seq_state_o, pll_areset_o} !== {3'd1, 1'b0}) begin n_err++; $display("FAIL areset_drop: state=%0d areset=%b want 1/0", seq_state_o, pll_areset_o); end
      step(12);
      pll_locked_async_i = 4'hF;
      step(2);
      n_cmp++; if (seq_state_o !== 3'd1) begin n_err++; $display("FAIL sync_latency: got %0d want 1", seq_state_o); end
      step(1);
      n_cmp++; if (seq_state_o !== 3'd2) begin n_err++; $display("FAIL settle_entry: got %0d want 2", seq_state_o); end
      step(15);
      n_cmp++; if ({seq_state_o, domain_rst_n_o} !== {3'd2, 4'h0}) begin n_err++; $display("FAIL settle_early: state=%0d dom=%b want 2/0000", seq_state_o, domain_rst_n_o); end
      step(1);
      n_cmp++; if ({seq_state_o, domain_rst_n_o} !== {3'd3, 4'b0001}) begin n_err++; $display("FAIL release0: state=%0d dom=%b want 3/0001", seq_state_o, domain_rst_n_o); end
      step(4);
      n_cmp++; if (domain_rst_n_o !== 4'b0011) begin n_err++; $display("FAIL release1: got %b want 0011", domain_rst_n_o); end
      step(4);
      n_cmp++; if ({seq_state_o, domain_rst_n_o, all_ready_o} !== {3'd3, 4'b0111, 1'b0}) begin n_err++; $display("FAIL release2: state=%0d dom=%b rdy=%b want 3/0111/0", seq_state_o, domain_rst_n_o, all_ready_o); end
      step(4);
      n_cmp++; if ({seq_state_o, domain_rst_n_o, all_ready_o, retry_count_o} !== {3'd4, 4'b1111, 1'b1, 4'd0}) begin n_err++; $display("FAIL run_entry: state=%0d dom=%b rdy=%b retry=%0d want 4/1111/1/0", seq_state_o, domain_rst_n_o, all_ready_o, retry_count_o); end
   endtask

   task automatic test_settle_glitch();
      do_reset();
      step(20);
      pll_locked_async_i = 4'hF;
      step(3);
      step(10);
      pll_locked_async_i = 4'hB;
      step(1);
      pll_locked_async_i = 4'hF;
      step(2);
      n_cmp++; if ({seq_state_o, domain_rst_n_o, retry_count_o} !== {3'd1, 4'h0, 4'd0}) begin n_err++; $display("FAIL glitch_back: state=%0d dom=%b retry=%0d want 1/0000/0", seq_state_o, domain_rst_n_o, retry_count_o); end
      step(1);
      n_cmp++; if (seq_state_o !== 3'd2) begin n_err++; $display("FAIL glitch_resettle: got %0d want 2", seq_state_o); end
      step(15);
      n_cmp++; if ({seq_state_o, domain_rst_n_o} !== {3'd2, 4'h0}) begin n_err++; $display("FAIL glitch_full_settle: state=%0d dom=%b want 2/0000", seq_state_o, domain_rst_n_o); end
      step(1);
      n_cmp++; if ({seq_state_o, domain_rst_n_o} !== {3'd3, 4'b0001}) begin n_err++; $display("FAIL glitch_release: state=%0d dom=%b want 3/0001", seq_state_o, domain_rst_n_o); end
      step(12);
      n_cmp++; if ({seq_state_o, domain_rst_n_o, retry_count_o} !== {3'd4, 4'hF, 4'd0}) begin n_err++; $display("FAIL glitch_run: state=%0d dom=%b retry=%0d want 4/1111/0", seq_state_o, domain_rst_n_o, retry_count_o); end
   endtask

   task automatic test_lock_loss();
      pll_locked_async_i = 4'hE;
      step(2);
      n_cmp++; if (seq_state_o !== 3'd4) begin n_err++; $display("FAIL loss_latency: got %0d want 4", seq_state_o); end
      step(1);
      n_cmp++; if ({seq_state_o, domain_rst_n_o, all_ready_o, pll_areset_o} !== {3'd5, 4'h0, 1'b0, 1'b1}) begin n_err++; $display("FAIL loss_fault: state=%0d dom=%b rdy=%b areset=%b want 5/0000/0/1", seq_state_o, domain_rst_n_o, all_ready_o, pll_areset_o); end
      n_cmp++; if ({lock_loss_count_o, retry_count_o} !== {8'd1, 4'd1}) begin n_err++; $display("FAIL loss_counts: loss=%0d retry=%0d want 1/1", lock_loss_count_o, retry_count_o); end
      pll_locked_async_i = 4'hF;
      step(1);
      n_cmp++; if ({seq_state_o, pll_areset_o} !== {3'd0, 1'b1}) begin n_err++; $display("FAIL loss_retry: state=%0d areset=%b want 0/1", seq_state_o, pll_areset_o); end
      step(8);
      n_cmp++; if (seq_state_o !== 3'd1) begin n_err++; $display("FAIL loss_wait: got %0d want 1", seq_state_o); end
      step(1);
      n_cmp++; if (seq_state_o !== 3'd2) begin n_err++; $display("FAIL loss_settle: got %0d want 2", seq_state_o); end
      step(16);
      n_cmp++; if ({seq_state_o, domain_rst_n_o} !== {3'd3, 4'b0001}) begin n_err++; $display("FAIL loss_release: state=%0d dom=%b want 3/0001", seq_state_o, domain_rst_n_o); end
      step(12);
      n_cmp++; if ({seq_state_o, all_ready_o, retry_count_o, lock_loss_count_o} !== {3'd4, 1'b1, 4'd0, 8'd1}) begin n_err++; $display("FAIL loss_rerun: state=%0d rdy=%b retry=%0d loss=%0d want 4/1/0/1", seq_state_o, all_ready_o, retry_count_o, lock_loss_count_o); end
   endtask

   task automatic test_timeout_halt();
      do_reset();
      pll_locked_async_i = 4'h7;
      step(107);
      n_cmp++; if (seq_state_o !== 3'd1) begin n_err++; $display("FAIL timeout_edge: got %0d want 1", seq_state_o); end
      step(1);
      n_cmp++; if ({seq_state_o, retry_count_o, pll_areset_o} !== {3'd5, 4'd1, 1'b1}) begin n_err++; $display("FAIL timeout1: state=%0d retry=%0d areset=%b want 5/1/1", seq_state_o, retry_count_o, pll_areset_o); end
      step(109);
      n_cmp++; if ({seq_state_o, retry_count_o} !== {3'd5, 4'd2}) begin n_err++; $display("FAIL timeout2: state=%0d retry=%0d want 5/2", seq_state_o, retry_count_o); end
      step(109);
      n_cmp++; if ({seq_state_o, retry_count_o, fault_halt_o} !== {3'd5, 4'd3, 1'b0}) begin n_err++; $display("FAIL timeout3: state=%0d retry=%0d halt=%b want 5/3/0", seq_state_o, retry_count_o, fault_halt_o); end
      step(1);
      n_cmp++; if ({seq_state_o, fault_halt_o, pll_areset_o, domain_rst_n_o} !== {3'd6, 1'b1, 1'b1, 4'h0}) begin n_err++; $display("FAIL halt_entry: state=%0d halt=%b areset=%b dom=%b want 6/1/1/0000", seq_state_o, fault_halt_o, pll_areset_o, domain_rst_n_o); end
      step(5);
      n_cmp++; if ({seq_state_o, retry_count_o} !== {3'd6, 4'd3}) begin n_err++; $display("FAIL halt_hold: state=%0d retry=%0d want 6/3", seq_state_o, retry_count_o); end
   endtask

   task automatic test_restart();
      pll_locked_async_i = 4'hF;
      sw_restart_i = 1'b1;
      step(1);
      sw_restart_i = 1'b0;
      n_cmp++; if ({seq_state_o, retry_count_o, fault_halt_o, pll_areset_o} !== {3'd0, 4'd0, 1'b0, 1'b1}) begin n_err++; $display("FAIL restart: state=%0d retry=%0d halt=%b areset=%b want 0/0/0/1", seq_state_o, retry_count_o, fault_halt_o, pll_areset_o); end
      step(8);
      n_cmp++; if (seq_state_o !== 3'd1) begin n_err++; $display("FAIL restart_wait: got %0d want 1", seq_state_o); end
      step(17);
      n_cmp++; if ({seq_state_o, domain_rst_n_o} !== {3'd3, 4'b0001}) begin n_err++; $display("FAIL restart_release: state=%0d dom=%b want 3/0001", seq_state_o, domain_rst_n_o); end
      step(12);
      n_cmp++; if ({seq_state_o, all_ready_o, domain_rst_n_o} !== {3'd4, 1'b1, 4'hF}) begin n_err++; $display("FAIL restart_run: state=%0d rdy=%b dom=%b want 4/1/1111", seq_state_o, all_ready_o, domain_rst_n_o); end
   endtask

   task automatic test_priority();
      pll_locked_async_i = 4'hE;
      step(2);
      sw_restart_i = 1'b1;
      step(1);
      sw_restart_i = 1'b0;
      pll_locked_async_i = 4'hF;
      n_cmp++; if ({seq_state_o, domain_rst_n_o, all_ready_o} !== {3'd0, 4'h0, 1'b0}) begin n_err++; $display("FAIL prio_state: state=%0d dom=%b rdy=%b want 0/0000/0", seq_state_o, domain_rst_n_o, all_ready_o); end
      n_cmp++; if ({lock_loss_count_o, retry_count_o} !== {8'd0, 4'd0}) begin n_err++; $display("FAIL prio_counts: loss=%0d retry=%0d want 0/0", lock_loss_count_o, retry_count_o); end
   endtask

   task automatic test_async_reset();
      step(8);
      n_cmp++; if (seq_state_o !== 3'd1) begin n_err++; $display("FAIL ar_wait: got %0d want 1", seq_state_o); end
      step(21);
      n_cmp++; if ({seq_state_o, domain_rst_n_o} !== {3'd3, 4'b0011}) begin n_err++; $display("FAIL ar_mid_release: state=%0d dom=%b want 3/0011", seq_state_o, domain_rst_n_o); end
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({seq_state_o, pll_areset_o, domain_rst_n_o, all_ready_o, fault_halt_o} !== {3'd0, 1'b1, 4'h0, 1'b0, 1'b0}) begin n_err++; $display("FAIL ar_outputs: state=%0d areset=%b dom=%b rdy=%b halt=%b want 0/1/0000/0/0", seq_state_o, pll_areset_o, domain_rst_n_o, all_ready_o, fault_halt_o); end
      n_cmp++; if ({retry_count_o, lock_loss_count_o} !== 12'h000) begin n_err++; $display("FAIL ar_counts: got %h want 000", {retry_count_o, lock_loss_count_o}); end
      step(1);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      pll_locked_async_i = 4'h0;
      sw_restart_i = 1'b0;
      test_reset();
      test_bringup();
      test_settle_glitch();
      test_lock_loss();
      test_timeout_halt();
      test_restart();
      test_priority();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
